// File: rtl/gpr_xfer_sequencer.sv
// Register-transfer sequencer for R0-R15: accepts one MOV/LDI/SWAP/ZERO command
// at a time and expands it into per-cycle GRin/GRout/BAout/T/IMM bus strobes.
module gpr_xfer_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_ra,
  input  logic [3:0]        cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [15:0]       GRin,
  output logic [15:0]       GRout,
  output logic              BAout,
  output logic              Tout,
  output logic              Tin,
  output logic              IMMout,
  output logic [DATA_W-1:0] imm_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_X1   = 3'd1;
  localparam logic [2:0] S_X2   = 3'd2;
  localparam logic [2:0] S_X3   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [3:0]        ra_q;
  logic [3:0]        rb_q;
  logic [DATA_W-1:0] imm_q;
  logic              accept;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  assign cmd_ready = (state == S_IDLE) && !clear;
  assign accept    = cmd_valid && cmd_ready;

  // Command capture and sequencing; clear aborts any command in flight
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= cmd_op;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            imm_q <= cmd_imm;
            if (cmd_op == OP_SWAP && cmd_ra == cmd_rb) state <= S_DONE;
            else                                       state <= S_X1;
          end
        end
        S_X1:    state <= (op_q == OP_SWAP) ? S_X2 : S_DONE;
        S_X2:    state <= S_X3;
        S_X3:    state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore strobe decode; only SWAP reaches X2/X3
  always_comb begin
    GRin   = '0;
    GRout  = '0;
    BAout  = 1'b0;
    Tout   = 1'b0;
    Tin    = 1'b0;
    IMMout = 1'b0;
    case (state)
      S_X1: begin
        case (op_q)
          OP_MOV: begin
            GRout = onehot16(rb_q);
            GRin  = onehot16(ra_q);
          end
          OP_LDI: begin
            IMMout = 1'b1;
            GRin   = onehot16(ra_q);
          end
          OP_ZERO: begin
            GRout = 16'h0001;
            BAout = 1'b1;
            GRin  = onehot16(ra_q);
          end
          default: begin
            GRout = onehot16(ra_q);
            Tin   = 1'b1;
          end
        endcase
      end
      S_X2: begin
        GRout = onehot16(rb_q);
        GRin  = onehot16(ra_q);
      end
      S_X3: begin
        Tout = 1'b1;
        GRin = onehot16(rb_q);
      end
      default: ;
    endcase
  end

  assign imm_data = imm_q;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule
